z16_mem_arbiter: RTL and testbench

Two-port arbiter that shares the Z16 CPU's single-port synchronous memory between the instruction-fetch unit and the load/store unit. Each cycle it grants at most one requester, drives the memory port, and routes the one-cycle-latency read data back to the requester that issued it. Data accesses have priority. An optional starvation guard forces a fetch grant after a bounded wait. It sits between the CPU core and the program/data RAM inside Z16CPU.

---
 rtl/z16_mem_arbiter_if.sv | 50 +++++
 rtl/z16_mem_arbiter.sv | 102 ++++++++++
 tb/tb_z16_mem_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/z16_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : z16_mem_arbiter_if
// Description : Request/grant/response bundle between the Z16 core ports,
//               the memory arbiter and the single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface z16_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_f_req;
    logic [ADDR_W-1:0] i_f_addr;
    logic              o_f_gnt;
    logic              o_f_rvalid;
    logic [DATA_W-1:0] o_f_rdata;

    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_gnt;
    logic              o_d_rvalid;
    logic [DATA_W-1:0] o_d_rdata;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_f_req, i_f_addr,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_f_req, i_f_addr,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/z16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : z16_mem_arbiter
// Description : Fetch/data arbiter for the Z16 single-port synchronous RAM.
//               Data has priority; define Z16_ARB_STARVE_GUARD_EN to force a
//               fetch grant after MAX_WAIT cycles of contention.
// Revision    : 1.0 - initial release
// ============================================================================
module z16_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    z16_mem_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] c_ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] c_DATA_ZERO = '0;

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("z16_mem_arbiter: MAX_WAIT must be at least 1");
    end

    logic w_f_gnt;
    logic w_d_gnt;
    logic w_force_f;

    logic rd_pend_f_d, rd_pend_f_q;
    logic rd_pend_d_d, rd_pend_d_q;

`ifdef Z16_ARB_STARVE_GUARD_EN
    localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

    logic [c_WAIT_W-1:0] wait_cnt_d, wait_cnt_q;

    assign w_force_f = (wait_cnt_q == c_WAIT_MAX);

    // Counts consecutive cycles a fetch has been refused; saturates at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.i_f_req || w_f_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != c_WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + c_WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign w_force_f = 1'b0;
`endif

    assign w_f_gnt = bus.i_f_req & (~bus.i_d_req | w_force_f);
    assign w_d_gnt = bus.i_d_req & ~w_f_gnt;

    always_comb begin
        bus.o_mem_addr  = c_ADDR_ZERO;
        bus.o_mem_wdata = c_DATA_ZERO;
        if (w_f_gnt) begin
            bus.o_mem_addr  = bus.i_f_addr;
        end else if (w_d_gnt) begin
            bus.o_mem_addr  = bus.i_d_addr;
            bus.o_mem_wdata = bus.i_d_wdata;
        end
    end

    assign bus.o_f_gnt  = w_f_gnt;
    assign bus.o_d_gnt  = w_d_gnt;
    assign bus.o_mem_en = w_f_gnt | w_d_gnt;
    assign bus.o_mem_we = w_d_gnt & bus.i_d_we;

    // Writes produce no response, so only data reads mark a pending return.
    always_comb begin
        rd_pend_f_d = w_f_gnt;
        rd_pend_d_d = w_d_gnt & ~bus.i_d_we;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_f_q <= 1'b0;
            rd_pend_d_q <= 1'b0;
        end else begin
            rd_pend_f_q <= rd_pend_f_d;
            rd_pend_d_q <= rd_pend_d_d;
        end
    end

    assign bus.o_f_rvalid = rd_pend_f_q;
    assign bus.o_d_rvalid = rd_pend_d_q;
    assign bus.o_f_rdata  = bus.i_mem_rdata;
    assign bus.o_d_rdata  = bus.i_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_z16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_z16_mem_arbiter
// Description : Directed self-checking bench for z16_mem_arbiter with a RAM
//               and a cycle-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z16_mem_arbiter;
    localparam int c_MAX_WAIT = 4;
`ifdef Z16_ARB_STARVE_GUARD_EN
    localparam bit c_GUARD = 1'b1;
`else
    localparam bit c_GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    z16_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(c_MAX_WAIT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // RAM (environment) and the model's own copy of its contents
    logic [15:0] ram     [0:255];
    logic [15:0] mdl_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'h1000 + 16'(i);
            mdl_mem[i] = 16'h1000 + 16'(i);
        end
        ram[16'h10]     = 16'hA5A5;
        mdl_mem[16'h10] = 16'hA5A5;
        bus.i_mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we) ram[bus.o_mem_addr[7:0]] <= bus.o_mem_wdata;
            else              bus.i_mem_rdata <= ram[bus.o_mem_addr[7:0]];
        end
    end

    // Reference model: expected responses due this cycle and fetch waiting time
    logic        exp_fv = 1'b0, exp_dv = 1'b0;
    logic [15:0] exp_frd = '0, exp_drd = '0;
    int          mdl_wait = 0;
    logic        nx_fv = 1'b0, nx_dv = 1'b0, nx_wr = 1'b0;
    logic [15:0] nx_frd = '0, nx_drd = '0, nx_wdata = '0;
    logic [7:0]  nx_waddr = '0;
    int          nx_wait = 0;

    always @(negedge clk) begin
        logic ef, ed, force_f;
        logic [15:0] eaddr, ewdata;
        force_f = c_GUARD && (mdl_wait >= c_MAX_WAIT);
        ed = bus.i_d_req && !(bus.i_f_req && force_f);
        ef = bus.i_f_req && !ed;
        eaddr  = ef ? bus.i_f_addr : (ed ? bus.i_d_addr : 16'h0);
        ewdata = (!ef && ed) ? bus.i_d_wdata : 16'h0;
        chk("f_gnt",     32'(bus.o_f_gnt),     32'(ef));
        chk("d_gnt",     32'(bus.o_d_gnt),     32'(ed));
        chk("mem_en",    32'(bus.o_mem_en),    32'(ef || ed));
        chk("mem_we",    32'(bus.o_mem_we),    32'(ed && bus.i_d_we));
        chk("mem_addr",  32'(bus.o_mem_addr),  32'(eaddr));
        chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(ewdata));
        chk("f_rvalid",  32'(bus.o_f_rvalid),  32'(exp_fv));
        chk("d_rvalid",  32'(bus.o_d_rvalid),  32'(exp_dv));
        if (exp_fv) chk("f_rdata", 32'(bus.o_f_rdata), 32'(exp_frd));
        if (exp_dv) chk("d_rdata", 32'(bus.o_d_rdata), 32'(exp_drd));
        nx_fv    = ef;
        nx_frd   = mdl_mem[bus.i_f_addr[7:0]];
        nx_dv    = ed && !bus.i_d_we;
        nx_drd   = mdl_mem[bus.i_d_addr[7:0]];
        nx_wr    = ed && bus.i_d_we;
        nx_waddr = bus.i_d_addr[7:0];
        nx_wdata = bus.i_d_wdata;
        nx_wait  = (bus.i_f_req && !ef) ? mdl_wait + 1 : 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_fv   <= 1'b0;
            exp_dv   <= 1'b0;
            mdl_wait <= 0;
        end else begin
            exp_fv   <= nx_fv;
            exp_dv   <= nx_dv;
            exp_frd  <= nx_frd;
            exp_drd  <= nx_drd;
            mdl_wait <= nx_wait;
        end
    end

    always @(posedge clk) begin
        if (nx_wr) mdl_mem[nx_waddr] <= nx_wdata;
    end

    task automatic cyc(input logic fr, input logic [15:0] fa, input logic dr,
                       input logic dwe, input logic [15:0] da, input logic [15:0] dwd);
        @(posedge clk);
        #1;
        bus.i_f_req   = fr;
        bus.i_f_addr  = fa;
        bus.i_d_req   = dr;
        bus.i_d_we    = dwe;
        bus.i_d_addr  = da;
        bus.i_d_wdata = dwd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    int f_cnt, d_cnt, first_f;

    initial begin
        bus.i_f_req = 1'b0; bus.i_f_addr = '0;
        bus.i_d_req = 1'b0; bus.i_d_we = 1'b0; bus.i_d_addr = '0; bus.i_d_wdata = '0;

        // Reset held, then released with no requests
        repeat (3) idle();
        @(posedge clk); #1 rst_n = 1'b1;
        idle();
        chk("rst_idle_gnt", 32'({bus.o_f_gnt, bus.o_d_gnt, bus.o_mem_en}), 32'h0);
        chk("rst_idle_rv",  32'({bus.o_f_rvalid, bus.o_d_rvalid}), 32'h0);

        // Fetch-only read
        cyc(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("fetch_gnt", 32'(bus.o_f_gnt), 32'h1);
        idle();
        chk("fetch_rv",    32'(bus.o_f_rvalid), 32'h1);
        chk("fetch_rdata", 32'(bus.o_f_rdata),  32'hA5A5);
        chk("fetch_drv",   32'(bus.o_d_rvalid), 32'h0);

        // Write followed by read-back of the same word
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        chk("wr_mem_we", 32'(bus.o_mem_we), 32'h1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
        chk("wr_no_rv", 32'(bus.o_d_rvalid), 32'h0);
        idle();
        chk("rd_rv",    32'(bus.o_d_rvalid), 32'h1);
        chk("rd_rdata", 32'(bus.o_d_rdata),  32'h1234);

        // Continuous contention for 12 cycles
        f_cnt = 0; d_cnt = 0; first_f = -1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0041, 16'h0);
            if (bus.o_f_gnt) begin
                f_cnt++;
                if (first_f < 0) first_f = i;
            end
            if (bus.o_d_gnt) d_cnt++;
        end
        idle();
        if (c_GUARD) begin
            chk("cont_f_cnt", 32'(f_cnt),   32'd2);
            chk("cont_d_cnt", 32'(d_cnt),   32'd10);
            chk("cont_first", 32'(first_f), 32'd4);
        end else begin
            chk("cont_f_cnt", 32'(f_cnt), 32'd0);
            chk("cont_d_cnt", 32'(d_cnt), 32'd12);
        end
        idle();

        // Alternating F, D, F
        cyc(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
        chk("alt1_frv", 32'(bus.o_f_rvalid), 32'h1);
        chk("alt1_fd",  32'(bus.o_f_rdata),  32'hA5A5);
        cyc(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("alt2_drv", 32'(bus.o_d_rvalid), 32'h1);
        chk("alt2_frv", 32'(bus.o_f_rvalid), 32'h0);
        chk("alt2_dd",  32'(bus.o_d_rdata),  32'h1234);
        idle();
        chk("alt3_frv", 32'(bus.o_f_rvalid), 32'h1);
        chk("alt3_fd",  32'(bus.o_f_rdata),  32'h1041);

        // Reset asserted with a fetch read in flight
        cyc(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("rstf_gnt", 32'(bus.o_f_gnt), 32'h1);
        #1;
        rst_n = 1'b0;
        bus.i_f_req = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("rstf_rv", 32'(bus.o_f_rvalid), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        cyc(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0);
        idle();
        chk("post_rv",    32'(bus.o_f_rvalid), 32'h1);
        chk("post_rdata", 32'(bus.o_f_rdata),  32'h1234);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
